// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and result bus for the DIV/REM unit.
// master drives operands, slave (the divider) returns results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: non-restoring multi-cycle divider, one quotient bit per clock.
// Optional abort port enabled by defining SEQ_DIVIDER_ABORT_EN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SEQ_DIVIDER_ABORT_EN
  input  logic abort,
`endif
  seq_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             zero_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   pr_step;
  logic [WIDTH:0]   r_fix;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             last;
  logic             kill;

`ifdef SEQ_DIVIDER_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  assign accept   = (state == IDLE) && bus.start;
  assign zero_div = (bus.divisor == '0);
  assign a_neg    = bus.signed_mode & bus.dividend[WIDTH-1];
  assign b_neg    = bus.signed_mode & bus.divisor[WIDTH-1];
  assign a_mag    = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag    = b_neg ? -bus.divisor : bus.divisor;

  // Partial remainder is WIDTH+1 bits; modular wrap in the shifted
  // intermediate is harmless because the step result always fits.
  assign pr_shift = {pr[WIDTH-1:0], dq[WIDTH-1]};
  assign pr_step  = pr[WIDTH] ? pr_shift + {1'b0, dv}
                              : pr_shift - {1'b0, dv};
  assign r_fix    = pr[WIDTH] ? pr + {1'b0, dv} : pr;
  assign q_out    = q_neg ? -dq : dq;
  assign r_out    = r_neg ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
  assign last     = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = zero_div ? DONE : ITER;
      ITER: if (last)      state_nxt = FIX;
      FIX:                 state_nxt = DONE;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Working registers: operand capture and one iteration per ITER cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr    <= '0;
      dq    <= '0;
      dv    <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && !zero_div) begin
      pr    <= '0;
      dq    <= a_mag;
      dv    <= b_mag;
      cnt   <= '0;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end else if (state == ITER) begin
      pr  <= pr_step;
      dq  <= {dq[WIDTH-2:0], ~pr_step[WIDTH]};
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers: written on divide-by-zero accept or at FIX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (accept && zero_div) begin
      bus.quotient    <= '1;
      bus.remainder   <= bus.dividend;
      bus.div_by_zero <= 1'b1;
    end else if (state == FIX && !kill) begin
      bus.quotient    <= q_out;
      bus.remainder   <= r_out;
      bus.div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider.
// Expected results come from plain integer division in the model.
module tb_seq_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

`ifdef SEQ_DIVIDER_ABORT_EN
  logic abort = 1'b0;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus));
`else
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           t;
  } exp_t;

  exp_t sq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sm);
    exp_t e;
    longint sx, sy, qq, rr;
    e.t = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (!sm) begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end else begin
      sx = $signed(a);
      sy = $signed(b);
      qq = sx / sy;
      rr = sx % sy;
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pop expected entry whenever the DUT reports done
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      if (sq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        e = sq.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", bus.div_by_zero, e.z);
        check("latency", cyc - e.t + 1, e.z ? 1 : W + 2);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sm,
                       bit track, bit second);
    exp_t e;
    int n = 0;
    wait_idle();
    bus.dividend = a;
    bus.divisor = b;
    bus.signed_mode = sm;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = model(a, b, sm);
    e.t = cyc;
    if (track) sq.push_back(e);
    check("busy_after_start", bus.busy, 1);
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    bus.signed_mode = $urandom_range(0, 1);
    if (second) begin
      repeat (9) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    if (track) begin
      while (sq.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sq.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done expected done");
        sq.delete();
      end
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W-1:0] q_hold, r_hold;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 1, 0);
    issue(32'hFFFFFF9C, 32'd7, 1'b1, 1, 0);
    issue(32'd100, 32'hFFFFFFF9, 1'b1, 1, 0);
    issue(32'd5, 32'd0, 1'b0, 1, 0);
    issue(32'd5, 32'd0, 1'b1, 1, 0);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 0);
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 1, 0);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1, 0);
    issue(32'h80000000, 32'd1, 1'b1, 1, 0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 0);
    issue(32'd1000000, 32'hFFFFFFF3, 1'b1, 1, 1);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = '1;
        3: b = $urandom;
        default: b = $urandom >> $urandom_range(1, 30);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      issue(a, b, 1'($urandom_range(0, 1)), 1, (b > 32'd100));
    end

    // Reset in mid-operation discards the division
    issue(32'd9999, 32'd10, 1'b0, 0, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    check("midrst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);

    issue(32'd77, 32'd5, 1'b0, 1, 0);

`ifdef SEQ_DIVIDER_ABORT_EN
    q_hold = bus.quotient;
    r_hold = bus.remainder;
    issue(32'd12345, 32'd3, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    check("abort_quotient", bus.quotient, q_hold);
    check("abort_remainder", bus.remainder, r_hold);
`else
    q_hold = '0;
    r_hold = '0;
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
